// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO bus owner: serialises one LSB or IF request at a time into
// little-endian byte transfers and returns a one-cycle success pulse.
//
// state | meaning
// IDLE  | bus free, waiting for an LSB (priority) or IF request
// READ  | issuing byte addresses and collecting returned bytes
// WRITE | driving store bytes, stalls on a full IO buffer
// DONE  | success pulse visible, requests ignored for this cycle
module mem_ctrl #(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [1:0]  IO_SEL     = 2'b11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  clr,
   input  logic                  LSB_S,
   input  logic                  LSB_op,
   input  logic [ADDR_WIDTH-1:0] LSB_pc,
   input  logic [2:0]            LSB_len,
   input  logic [31:0]           LSB_result,
   output logic                  LSB_success,
   output logic [31:0]           LSB_value,
   input  logic                  IF_S,
   input  logic [ADDR_WIDTH-1:0] IF_pc,
   output logic                  IF_success,
   output logic [31:0]           IF_inst,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state, state_nxt;
   logic                  owner_lsb;
   logic                  op_wr;
   logic [2:0]            len;
   logic [2:0]            cnt;
   logic [ADDR_WIDTH-1:0] pc;
   logic [31:0]           data;
   logic [31:0]           rbuf;
   logic                  wr_q;
   logic                  lsb_succ_q;
   logic                  if_succ_q;

   logic                  accept;
   logic                  io_stall;
   logic                  rd_last;
   logic                  wr_last;
   logic                  rd_flush;
   logic [2:0]            nxt_cnt;
   logic [1:0]            cap_lane;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [31:0]           rd_word;

   assign nxt_cnt  = cnt + 3'd1;
   assign cap_lane = 2'(cnt - 3'd1);
   assign nxt_addr = pc + ADDR_WIDTH'(nxt_cnt);
   assign req_pc   = LSB_S ? LSB_pc : IF_pc;
   assign io_stall = (state == WRITE) && (mem_a[17:16] == IO_SEL) && io_buffer_full;
   assign rd_last  = (cnt == len);
   assign wr_last  = (cnt == len - 3'd1);
   // A flushed read must not be seen as complete even while already in DONE.
   assign rd_flush = clr && (state == DONE) && !op_wr;

   assign mem_wr      = wr_q && rdy && !io_stall;
   assign LSB_success = lsb_succ_q && !rd_flush;
   assign IF_success  = if_succ_q && !rd_flush;

   // Byte returned this cycle belongs to the address issued two edges ago.
   always_comb begin
      rd_word = rbuf;
      if (cnt != 3'd0) rd_word[{cap_lane, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= IDLE;
      else if (rdy) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (LSB_S || IF_S) begin
               accept    = 1'b1;
               state_nxt = (LSB_S && LSB_op) ? WRITE : READ;
            end
         end
         READ: begin
            if (clr)          state_nxt = IDLE;
            else if (rd_last) state_nxt = DONE;
         end
         WRITE: begin
            if (!io_stall && wr_last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_lsb  <= 1'b0;
         op_wr      <= 1'b0;
         len        <= 3'd0;
         cnt        <= 3'd0;
         pc         <= '0;
         data       <= 32'd0;
         rbuf       <= 32'd0;
         wr_q       <= 1'b0;
         mem_a      <= '0;
         mem_dout   <= 8'd0;
         lsb_succ_q <= 1'b0;
         if_succ_q  <= 1'b0;
         LSB_value  <= 32'd0;
         IF_inst    <= 32'd0;
      end else if (rdy) begin
         lsb_succ_q <= 1'b0;
         if_succ_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  owner_lsb <= LSB_S;
                  op_wr     <= LSB_S && LSB_op;
                  len       <= LSB_S ? LSB_len : 3'd4;
                  pc        <= req_pc;
                  data      <= LSB_result;
                  rbuf      <= 32'd0;
                  cnt       <= 3'd0;
                  mem_a     <= req_pc;
                  wr_q      <= LSB_S && LSB_op;
                  if (LSB_S && LSB_op) mem_dout <= LSB_result[7:0];
               end
            end
            READ: begin
               if (!clr) begin
                  cnt  <= nxt_cnt;
                  rbuf <= rd_word;
                  if (nxt_cnt < len) mem_a <= nxt_addr;
                  if (rd_last) begin
                     if (owner_lsb) begin
                        LSB_value  <= rd_word;
                        lsb_succ_q <= 1'b1;
                     end else begin
                        IF_inst   <= rd_word;
                        if_succ_q <= 1'b1;
                     end
                  end
               end
            end
            WRITE: begin
               if (!io_stall) begin
                  if (wr_last) begin
                     wr_q       <= 1'b0;
                     lsb_succ_q <= 1'b1;
                  end else begin
                     cnt      <= nxt_cnt;
                     mem_a    <= nxt_addr;
                     mem_dout <= data[{nxt_cnt[1:0], 3'b000} +: 8];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model, scoreboard of expected completions,
// immediate-assertion checks on bus timing and data.
module tb_mem_ctrl;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rdy = 1'b1;
   logic          clr = 1'b0;
   logic          LSB_S = 1'b0;
   logic          LSB_op = 1'b0;
   logic [AW-1:0] LSB_pc = '0;
   logic [2:0]    LSB_len = 3'd0;
   logic [31:0]   LSB_result = 32'd0;
   logic          LSB_success;
   logic [31:0]   LSB_value;
   logic          IF_S = 1'b0;
   logic [AW-1:0] IF_pc = '0;
   logic          IF_success;
   logic [31:0]   IF_inst;
   logic [7:0]    mem_din = 8'd0;
   logic [7:0]    mem_dout;
   logic [AW-1:0] mem_a;
   logic          mem_wr;
   logic          io_buffer_full = 1'b0;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_WIDTH(AW), .IO_SEL(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .LSB_S(LSB_S), .LSB_op(LSB_op), .LSB_pc(LSB_pc), .LSB_len(LSB_len),
      .LSB_result(LSB_result), .LSB_success(LSB_success), .LSB_value(LSB_value),
      .IF_S(IF_S), .IF_pc(IF_pc), .IF_success(IF_success), .IF_inst(IF_inst),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   // RAM model: one-cycle read latency, logs every byte written
   logic [7:0]  ram [logic [31:0]];
   logic [39:0] wlog [$];
   always @(posedge clk) begin
      if (rst) begin
         ram[32'h100] = 8'h13;
         ram[32'h101] = 8'h05;
         ram[32'h102] = 8'h00;
         ram[32'h103] = 8'h00;
      end else begin
         mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
         if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wlog.push_back({mem_a, mem_dout});
         end
      end
   end

   typedef struct packed {logic lsb; logic chk; logic [31:0] val;} exp_t;
   exp_t exp_q [$];
   int checks = 0;
   int fails = 0;
   int cyc_n = 0;
   int lsb_pulses = 0;
   int if_pulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic lsb, input logic chk, input logic [31:0] val);
      exp_q.push_back({lsb, chk, val});
   endtask

   task automatic sb_pop(input logic lsb, input logic [31:0] val);
      exp_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
         fails++;
         $error("FAIL sb_unexpected observed pulse owner_lsb=%0d expected none", lsb);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_owner", 32'(lsb), 32'(e.lsb));
         if (e.chk) check("sb_value", val, e.val);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      cyc_n++;
      if (LSB_success) begin lsb_pulses++; sb_pop(1'b1, LSB_value); end
      if (IF_success)  begin if_pulses++;  sb_pop(1'b0, IF_inst);   end
   endtask

   task automatic wait_pulse(input logic lsb, input string tag, output int at);
      int p0;
      p0 = lsb ? lsb_pulses : if_pulses;
      at = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         if ((lsb ? lsb_pulses : if_pulses) != p0) begin
            at = cyc_n;
            break;
         end
      end
      checks++;
      assert (at >= 0) else begin
         fails++;
         $error("FAIL %s_timeout observed no pulse in 40 cycles expected a pulse", tag);
      end
   endtask

   task automatic check_writes(input string tag, input int w0, input logic [31:0] a,
                               input logic [31:0] d, input int n);
      check({tag, "_count"}, 32'(wlog.size() - w0), 32'(n));
      for (int k = 0; k < n; k++)
         if (w0 + k < wlog.size())
            check($sformatf("%s_byte%0d", tag, k), 32'(wlog[w0+k]),
                  32'({a + 32'(k), d[8*k +: 8]}));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed no finish expected finish before 100us");
      $fatal(1);
   end

   initial begin
      int t0, at, w0, p;
      logic [31:0] d;

      step(); step();
      check("rst_mem_wr", 32'(mem_wr), 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_dout", 32'(mem_dout), 0);
      check("rst_lsb_succ", 32'(LSB_success), 0);
      check("rst_if_succ", 32'(IF_success), 0);
      check("rst_lsb_value", LSB_value, 0);
      check("rst_if_inst", IF_inst, 0);
      rst = 1'b0;
      step();

      // 1: instruction fetch
      IF_S = 1'b1; IF_pc = 32'h100; push_exp(1'b0, 1'b1, 32'h0000_0513); t0 = cyc_n + 1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("t1_addr%0d", k), mem_a, 32'h100 + 32'(k));
         check("t1_no_wr", 32'(mem_wr), 0);
      end
      step(); check("t1_early", 32'(IF_success), 0);
      step(); check("t1_succ", 32'(IF_success), 1); check("t1_latency", 32'(cyc_n - t0), 5);
      IF_S = 1'b0;
      step(); check("t1_one_cycle", 32'(IF_success), 0);
      check("t1_pulses", 32'(if_pulses), 1);

      // 2: word store, requester keeps S through DONE
      LSB_S = 1'b1; LSB_op = 1'b1; LSB_len = 3'd4; LSB_pc = 32'h200; LSB_result = 32'hDEAD_BEEF;
      d = 32'hDEAD_BEEF; push_exp(1'b1, 1'b0, 32'd0); w0 = wlog.size();
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("t2_wr%0d", k), 32'(mem_wr), 1);
         check($sformatf("t2_addr%0d", k), mem_a, 32'h200 + 32'(k));
         check($sformatf("t2_dout%0d", k), 32'(mem_dout), 32'(d[8*k +: 8]));
      end
      step(); check("t2_wr_end", 32'(mem_wr), 0); check("t2_succ", 32'(LSB_success), 1);
      step(); check("t2_done_no_wr", 32'(mem_wr), 0); check("t2_succ_off", 32'(LSB_success), 0);
      LSB_S = 1'b0;
      step(); check("t2_idle_no_wr", 32'(mem_wr), 0);
      check_writes("t2_log", w0, 32'h200, d, 4);

      // 3: LSB halfword load beats a simultaneous fetch
      LSB_S = 1'b1; LSB_op = 1'b0; LSB_len = 3'd2; LSB_pc = 32'h200;
      IF_S = 1'b1; IF_pc = 32'h100;
      push_exp(1'b1, 1'b1, 32'h0000_BEEF); push_exp(1'b0, 1'b1, 32'h0000_0513); t0 = cyc_n + 1;
      step(); check("t3_addr0", mem_a, 32'h200);
      step(); check("t3_addr1", mem_a, 32'h201);
      step(); check("t3_early", 32'(LSB_success), 0);
      step(); check("t3_lsb_succ", 32'(LSB_success), 1); check("t3_if_quiet", 32'(IF_success), 0);
      LSB_S = 1'b0;
      step(); check("t3_if_not_in_done", mem_a, 32'h201);
      step(); check("t3_if_accept", mem_a, 32'h100);
      wait_pulse(1'b0, "t3_if", at);
      check("t3_if_latency", 32'(at - (t0 + 5)), 5);
      IF_S = 1'b0;
      step();

      // 4: IO store stalled by full UART buffer
      LSB_S = 1'b1; LSB_op = 1'b1; LSB_len = 3'd1; LSB_pc = 32'h3_0000; LSB_result = 32'h0000_005A;
      io_buffer_full = 1'b1; push_exp(1'b1, 1'b0, 32'd0); w0 = wlog.size();
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("t4_stall%0d", k), 32'(mem_wr), 0);
         check($sformatf("t4_hold%0d", k), mem_a, 32'h3_0000);
      end
      io_buffer_full = 1'b0;
      #1 check("t4_release_wr", 32'(mem_wr), 1);
      step(); check("t4_succ", 32'(LSB_success), 1); check("t4_wr_end", 32'(mem_wr), 0);
      LSB_S = 1'b0;
      check_writes("t4_log", w0, 32'h3_0000, 32'h0000_005A, 1);
      step();

      // 5a: flush on the second cycle of a fetch
      IF_S = 1'b1; IF_pc = 32'h100; p = if_pulses;
      step(); step();
      clr = 1'b1; IF_S = 1'b0;
      step(); check("t5_abort_addr", mem_a, 32'h101); check("t5_abort_succ", 32'(IF_success), 0);
      clr = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("t5_no_pulse", 32'(if_pulses - p), 0);
      IF_S = 1'b1; push_exp(1'b0, 1'b1, 32'h0000_0513); t0 = cyc_n + 1;
      wait_pulse(1'b0, "t5_refetch", at);
      check("t5_refetch_latency", 32'(at - t0), 5);
      IF_S = 1'b0;
      step();

      // 5b: flush throughout a store does not abort it
      LSB_S = 1'b1; LSB_op = 1'b1; LSB_len = 3'd2; LSB_pc = 32'h210; LSB_result = 32'h0000_1234;
      clr = 1'b1; push_exp(1'b1, 1'b0, 32'd0); w0 = wlog.size(); t0 = cyc_n + 1;
      wait_pulse(1'b1, "t5_store", at);
      check("t5_store_latency", 32'(at - t0), 2);
      LSB_S = 1'b0; clr = 1'b0;
      check_writes("t5_log", w0, 32'h210, 32'h0000_1234, 2);
      step();

      // 6: asynchronous reset in the middle of a store
      LSB_S = 1'b1; LSB_op = 1'b1; LSB_len = 3'd4; LSB_pc = 32'h220; LSB_result = 32'hCAFE_F00D;
      push_exp(1'b1, 1'b0, 32'd0);
      step(); check("t6_wr0", 32'(mem_wr), 1);
      step(); check("t6_wr1", 32'(mem_wr), 1); check("t6_addr1", mem_a, 32'h221);
      rst = 1'b1;
      #1;
      check("t6_rst_wr", 32'(mem_wr), 0);
      check("t6_rst_addr", mem_a, 0);
      check("t6_rst_lsb_succ", 32'(LSB_success), 0);
      check("t6_rst_if_succ", 32'(IF_success), 0);
      exp_q.delete();
      LSB_S = 1'b0;
      step();
      rst = 1'b0;
      step();
      LSB_S = 1'b1; LSB_op = 1'b0; LSB_len = 3'd4; LSB_pc = 32'h200;
      push_exp(1'b1, 1'b1, 32'hDEAD_BEEF); t0 = cyc_n + 1;
      wait_pulse(1'b1, "t6_load", at);
      check("t6_load_latency", 32'(at - t0), 5);
      LSB_S = 1'b0;
      step();

      // 7: rdy low mid-store re-drives the interrupted byte
      LSB_S = 1'b1; LSB_op = 1'b1; LSB_len = 3'd2; LSB_pc = 32'h240; LSB_result = 32'h0000_7788;
      push_exp(1'b1, 1'b0, 32'd0); w0 = wlog.size();
      step(); check("t7_wr0", 32'(mem_wr), 1); check("t7_addr0", mem_a, 32'h240);
      rdy = 1'b0;
      #1 check("t7_rdy_low_wr", 32'(mem_wr), 0);
      step(); check("t7_frozen_wr", 32'(mem_wr), 0); check("t7_frozen_addr", mem_a, 32'h240);
      rdy = 1'b1;
      step(); check("t7_resume_addr", mem_a, 32'h241); check("t7_resume_wr", 32'(mem_wr), 1);
      wait_pulse(1'b1, "t7_store", at);
      LSB_S = 1'b0;
      check_writes("t7_log", w0, 32'h240, 32'h0000_7788, 2);
      step();

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sole owner of the byte-wide RAM/IO bus. Sits directly downstream of the load/store buffer (LSB) and of instruction fetch (IF).
- Accepts one multi-byte read or write request at a time and serialises it into little-endian byte transfers.
- Returns a one-cycle success pulse with the assembled data.
- LSB requests have priority over IF requests.

Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- IO_SEL, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global ready; when low, all state freezes
- clr  in  1  misprediction flush
- LSB_S  in  1  LSB request valid, held until LSB_success is seen
- LSB_op  in  1  0=read, 1=write
- LSB_pc  in  ADDR_WIDTH  byte address
- LSB_len  in  3  byte count: 1, 2 or 4
- LSB_result  in  32  store data; low LSB_len bytes are used
- LSB_success  out  1  one-cycle completion pulse
- LSB_value  out  32  load data, zero-extended
- IF_S  in  1  fetch request valid, held until IF_success
- IF_pc  in  ADDR_WIDTH  fetch address; always 4 bytes
- IF_success  out  1  one-cycle completion pulse
- IF_inst  out  32  fetched word
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM address
- mem_wr  out  1  1=write this cycle
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE, byte counter=0.
  - mem_wr=0, mem_a=0, mem_dout=0.
  - LSB_success=0, IF_success=0, LSB_value=0, IF_inst=0.
- RAM read timing: data for the address driven in cycle c is valid on mem_din in cycle c+1.
- States: IDLE, READ, WRITE, DONE.
- IDLE, at a clock edge:
  - LSB_S=1 → latch pc, len, op and data; owner=LSB.
  - else IF_S=1 → owner=IF, len=4, op=read.
  - A request is accepted at this edge (E0). Byte 0 is driven in the following cycle: mem_a=pc, plus mem_wr=1 and mem_dout=data[7:0] for a write.
  - Next state is READ or WRITE.
  - IF and LSB both asserted → LSB wins; IF stays pending.
- READ:
  - Drives address pc+k for k=0..len-1 on successive cycles.
  - Captures mem_din into byte lane k one cycle after that address.
  - At the edge that captures the last byte (E0+len+1): pulse the owner's success, drive that owner's value output, go to DONE.
  - Unused upper bytes of the value are 0.
- WRITE:
  - Drives byte k = data[8k+7:8k] at pc+k with mem_wr=1, one byte per cycle.
  - At E0+len: mem_wr=0, LSB_success=1, go to DONE.
- IO stall: if the write address has addr[17:16]==IO_SEL and io_buffer_full=1, hold the current byte with mem_wr=0 and do not advance until io_buffer_full=0.
- DONE:
  - Lasts exactly one cycle; the success pulse is high during it.
  - New requests are ignored in DONE because the requester is still asserting S that cycle.
  - Returns to IDLE.
  - Back-to-back requests therefore have at least one idle cycle between the success pulse and the next acceptance.
- Outside active WRITE cycles: mem_wr=0 and mem_a holds its last value.
- rdy=0: every register holds. mem_wr is forced to 0, and the interrupted write byte is re-driven when rdy returns.
- clr=1:
  - READ or DONE-for-read states abort to IDLE with no success pulse; this applies to both owners.
  - WRITE is never aborted. It completes, and LSB_success pulses normally even if clr is high in the success cycle.
  - A clr in IDLE has no effect.
- Only byte addresses are used; no alignment is required. Address arithmetic pc+k wraps modulo 2^ADDR_WIDTH.

Test Plan:
1. After reset, IF_S=1, IF_pc=0x100, RAM bytes 0x13,0x05,0x00,0x00 at 0x100..0x103 → mem_a steps 0x100..0x103. IF_success high exactly one cycle, 5 edges after acceptance, with IF_inst=0x00000513.
2. LSB_S=1, op=1, len=4, pc=0x200, result=0xDEADBEEF → mem_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x200..0x203. LSB_success pulses once at E0+4; no second transfer starts in the DONE cycle.
3. LSB load len=2 at 0x200 and IF_S asserted in the same cycle → the LSB transfer runs first and LSB_value=0x0000BEEF. IF is accepted only after DONE.
4. Store len=1 to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 during the stall, the byte is written once after release, then LSB_success pulses.
5. clr asserted on the 2nd cycle of an IF read → no IF_success and state back to IDLE. clr during an LSB store → the store completes and LSB_success still pulses.
6. rst asserted mid-WRITE (asynchronously) → mem_wr=0 and both success outputs=0 immediately. The next request runs normally.
